spi_txn_ctrl: RTL and testbench



---
 rtl/spi_ctrl_pkg.sv | 19 +
 rtl/spi_txn_ctrl_if.sv | 39 +++
 rtl/spi_cs_timer.sv | 27 ++
 rtl/spi_txn_ctrl.sv | 157 +++++++++++++++
 tb/tb_spi_txn_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI transaction sequencer and its CS timer.
package spi_ctrl_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    localparam int unsigned DEF_CS_SETUP_CLKS = 50;
    localparam int unsigned DEF_CS_HOLD_CLKS  = 50;
    localparam int unsigned DEF_CS_IDLE_CLKS  = 100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_txn_ctrl_if.sv
// Command/data/engine signal bundle of spi_txn_ctrl; slave = controller view.
interface spi_txn_ctrl_if #(
    parameter int unsigned LEN_W = 8
);
    import spi_ctrl_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_W-1:0]      cmd_len;
    logic                  abort;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  rx_valid;
    logic [SPI_BYTE_W-1:0] rx_data;
    logic                  txn_done;
    logic                  txn_aborted;
    logic                  cs_n;
    logic                  eng_start;
    logic [SPI_BYTE_W-1:0] eng_tx_byte;
    logic                  eng_busy;
    logic                  eng_done;
    logic [SPI_BYTE_W-1:0] eng_rx_byte;

    modport slave (
        input  cmd_valid, cmd_len, abort, tx_valid, tx_data,
               eng_busy, eng_done, eng_rx_byte,
        output cmd_ready, tx_ready, rx_valid, rx_data, txn_done, txn_aborted,
               cs_n, eng_start, eng_tx_byte
    );

    modport master (
        output cmd_valid, cmd_len, abort, tx_valid, tx_data,
               eng_busy, eng_done, eng_rx_byte,
        input  cmd_ready, tx_ready, rx_valid, rx_data, txn_done, txn_aborted,
               cs_n, eng_start, eng_tx_byte
    );

endinterface

// File: rtl/spi_cs_timer.sv
// Loadable down-counter for chip-select timing; expired marks the last cycle of a
// loaded interval, and a load value of 0 is treated as 1.
module spi_cs_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_txn_ctrl.sv
// Sequences one chip-select framed multi-byte transaction through the byte engine,
// with programmable CS setup/hold/idle timing and early abort.
module spi_txn_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W         = 8,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned CS_SETUP_CLKS = DEF_CS_SETUP_CLKS,
    parameter int unsigned CS_HOLD_CLKS  = DEF_CS_HOLD_CLKS,
    parameter int unsigned CS_IDLE_CLKS  = DEF_CS_IDLE_CLKS
) (
    input logic           clk,
    input logic           reset,
    spi_txn_ctrl_if.slave bus
);

    state_t                state;
    logic [LEN_W-1:0]      remaining;
    logic                  abort_flag;
    logic                  cs_n_q;
    logic                  rx_valid_q;
    logic [SPI_BYTE_W-1:0] rx_data_q;
    logic                  txn_done_q;
    logic                  txn_aborted_q;
    logic                  eng_start_q;
    logic [SPI_BYTE_W-1:0] eng_tx_byte_q;

    logic                  tx_ready_c;
    logic                  tx_hs;
    logic                  abort_early;
    logic                  xfer_last;
    logic                  to_hold;
    logic                  timer_load;
    logic [CNT_W-1:0]      timer_val;
    logic                  timer_expired;

    // Abort beats a same-cycle tx handshake, so it gates tx_ready directly.
    assign tx_ready_c  = (state == ST_FETCH) && !bus.eng_busy && !bus.abort;
    assign tx_hs       = bus.tx_valid && tx_ready_c;
    assign abort_early = bus.abort && ((state == ST_SETUP) || (state == ST_FETCH));
    assign xfer_last   = (state == ST_XFER) && bus.eng_done &&
                         ((remaining == LEN_W'(1)) || abort_flag || bus.abort);
    assign to_hold     = abort_early || xfer_last;

    // The timer must load on the same edge the FSM enters a timed state, so the
    // entry conditions above are shared between this block and the FSM.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        if ((state == ST_IDLE) && bus.cmd_valid && (bus.cmd_len != '0)) begin
            timer_load = 1'b1;
            timer_val  = CNT_W'(CS_SETUP_CLKS);
        end else if (to_hold) begin
            timer_load = 1'b1;
            timer_val  = CNT_W'(CS_HOLD_CLKS);
        end else if ((state == ST_HOLD) && timer_expired) begin
            timer_load = 1'b1;
            timer_val  = CNT_W'(CS_IDLE_CLKS);
        end
    end

    spi_cs_timer #(.CNT_W(CNT_W)) u_cs_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            abort_flag    <= 1'b0;
            cs_n_q        <= 1'b1;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            txn_done_q    <= 1'b0;
            txn_aborted_q <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_tx_byte_q <= '0;
        end else begin
            rx_valid_q    <= 1'b0;
            txn_done_q    <= 1'b0;
            txn_aborted_q <= 1'b0;
            eng_start_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        remaining  <= bus.cmd_len;
                        abort_flag <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            txn_done_q <= 1'b1;
                        end else begin
                            cs_n_q <= 1'b0;
                            state  <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort_early) begin
                        abort_flag <= 1'b1;
                        state      <= ST_HOLD;
                    end else if (timer_expired) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (abort_early) begin
                        abort_flag <= 1'b1;
                        state      <= ST_HOLD;
                    end else if (tx_hs) begin
                        eng_tx_byte_q <= bus.tx_data;
                        eng_start_q   <= 1'b1;
                        state         <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (bus.abort) begin
                        abort_flag <= 1'b1;
                    end
                    if (bus.eng_done) begin
                        rx_data_q  <= bus.eng_rx_byte;
                        rx_valid_q <= 1'b1;
                        remaining  <= remaining - LEN_W'(1);
                        state      <= xfer_last ? ST_HOLD : ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (timer_expired) begin
                        cs_n_q <= 1'b1;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_expired) begin
                        txn_done_q    <= 1'b1;
                        txn_aborted_q <= abort_flag;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.tx_ready    = tx_ready_c;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.txn_done    = txn_done_q;
    assign bus.txn_aborted = txn_aborted_q;
    assign bus.cs_n        = cs_n_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.eng_tx_byte = eng_tx_byte_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Bench for spi_txn_ctrl: byte-engine model, event monitor, vector table, timing,
// reset and randomized transactions checked against a transaction-level model.
module tb_spi_txn_ctrl;

    localparam int SETUP = 4;
    localparam int HOLD  = 3;
    localparam int IDLE  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    spi_txn_ctrl_if #(.LEN_W(8)) bus ();

    spi_txn_ctrl #(
        .LEN_W         (8),
        .CNT_W         (8),
        .CS_SETUP_CLKS (SETUP),
        .CS_HOLD_CLKS  (HOLD),
        .CS_IDLE_CLKS  (IDLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Byte engine model: random latency, returns the sent byte XOR 0x99.
    logic       eng_busy_m = 1'b0;
    logic       eng_done_m = 1'b0;
    logic [7:0] eng_rx_m   = '0;
    logic [7:0] held       = '0;
    int         lat        = 0;
    logic       stray_done = 1'b0;

    assign bus.eng_busy    = eng_busy_m;
    assign bus.eng_done    = eng_done_m | stray_done;
    assign bus.eng_rx_byte = stray_done ? 8'hEE : eng_rx_m;

    always @(posedge clk) begin
        if (reset) begin
            eng_busy_m <= 1'b0;
            eng_done_m <= 1'b0;
            eng_rx_m   <= '0;
        end else begin
            eng_done_m <= 1'b0;
            if (bus.eng_start && !eng_busy_m) begin
                eng_busy_m <= 1'b1;
                held       <= bus.eng_tx_byte;
                lat        <= int'($urandom_range(1, 5));
            end else if (eng_busy_m) begin
                if (lat <= 1) begin
                    eng_busy_m <= 1'b0;
                    eng_done_m <= 1'b1;
                    eng_rx_m   <= held ^ 8'h99;
                end else begin
                    lat <= lat - 1;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge and logs events.
    logic [7:0] start_q[$];
    logic [7:0] rx_q[$];
    int   done_cnt = 0, falls = 0, rises = 0, hs_cnt = 0, viol = 0;
    int   acc_cyc = 0, start_cyc = 0, rx_cyc = 0, done_cyc = 0;
    int   edone_cyc = 0, rise_cyc = 0, fall_cyc = 0, hs_cyc = 0;
    bit   done_ab = 1'b0;
    logic cs_prev = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
            if (bus.tx_valid && bus.tx_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
            end
            if (bus.eng_start) begin
                start_q.push_back(bus.eng_tx_byte);
                start_cyc = cyc;
                if (bus.cs_n || eng_busy_m) viol++;
            end
            if (bus.rx_valid) begin
                rx_q.push_back(bus.rx_data);
                rx_cyc = cyc;
            end
            if (bus.txn_done) begin
                done_cnt++;
                done_ab  = bus.txn_aborted;
                done_cyc = cyc;
            end
            if (bus.txn_aborted && !bus.txn_done) viol++;
            if (bus.tx_ready && bus.abort) viol++;
            if (eng_done_m) edone_cyc = cyc;
            if (bus.cs_n && !cs_prev) begin
                rises++;
                rise_cyc = cyc;
            end
            if (!bus.cs_n && cs_prev) begin
                falls++;
                fall_cyc = cyc;
            end
        end
        cs_prev = bus.cs_n;
    end

    // Transaction-level reference: abort_at 0 = none, k>0 = during byte k,
    // -1 = during CS setup, -2 = together with a tx handshake.
    function automatic int model_bytes(input int len, input int abort_at);
        if (len == 0 || abort_at < 0) return 0;
        if (abort_at == 0 || abort_at > len) return len;
        return abort_at;
    endfunction

    function automatic bit model_aborted(input int len, input int abort_at);
        return (len != 0) && (abort_at < 0 || (abort_at >= 1 && abort_at <= len));
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.cmd_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic run_txn(input string name, input int len, input int abort_at,
                           input int stall, input bit stray, input logic [7:0] base,
                           input int exp_bytes, input bit exp_ab);
        int   s0 = start_q.size();
        int   r0 = rx_q.size();
        int   d0 = done_cnt;
        int   f0 = falls;
        int   q0 = rises;
        int   h0 = hs_cnt;
        int   stall_left = stall;
        bit   ab_sent = 1'b0;
        int   nstart, nrx;
        wait_ready(name);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        bus.tx_valid  = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.abort     = (abort_at == -1);
        stray_done    = stray;
        for (int n = 0; n < 3000 && done_cnt == d0; n++) begin
            int idx;
            idx = hs_cnt - h0;
            bus.tx_data = 8'(base + idx);
            if (abort_at == -2 && !ab_sent) begin
                if (bus.tx_ready) begin
                    bus.tx_valid = 1'b1;
                    bus.abort    = 1'b1;
                    ab_sent      = 1'b1;
                end else begin
                    bus.tx_valid = 1'b0;
                end
            end else if (idx == 1 && stall_left > 0) begin
                bus.tx_valid = 1'b0;
                stall_left--;
            end else begin
                bus.tx_valid = (idx < len);
            end
            if (abort_at > 0 && !ab_sent && (start_q.size() - s0) == abort_at) begin
                bus.abort = 1'b1;
                ab_sent   = 1'b1;
            end
            @(posedge clk); #1;
            bus.abort  = 1'b0;
            stray_done = 1'b0;
        end
        bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nstart = start_q.size() - s0;
        nrx    = rx_q.size() - r0;
        check({name, "_txn_done_count"}, done_cnt - d0, 1);
        check({name, "_eng_start_count"}, nstart, exp_bytes);
        check({name, "_rx_valid_count"}, nrx, exp_bytes);
        check({name, "_tx_consumed"}, hs_cnt - h0, exp_bytes);
        check({name, "_txn_aborted"}, int'(done_ab), int'(exp_ab));
        check({name, "_cs_falls"}, falls - f0, (len != 0) ? 1 : 0);
        check({name, "_cs_rises"}, rises - q0, (len != 0) ? 1 : 0);
        for (int i = 0; i < exp_bytes && i < nstart && i < nrx; i++) begin
            check({name, "_eng_tx_byte"}, int'(start_q[s0 + i]), int'(8'(base + i)));
            check({name, "_rx_data"}, int'(rx_q[r0 + i]), int'(8'(base + i) ^ 8'h99));
        end
        if (len == 0) check({name, "_zero_len_latency"}, done_cyc - acc_cyc, 1);
    endtask

    typedef struct {
        string      name;
        int         len;
        int         abort_at;
        int         stall;
        bit         stray;
        logic [7:0] base;
        int         exp_bytes;
        bit         exp_ab;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.abort     = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;

        tbl[0] = '{"single",      1,  0,  0, 1'b0, 8'hA5, 1, 1'b0};
        tbl[1] = '{"three",       3,  0,  0, 1'b0, 8'h01, 3, 1'b0};
        tbl[2] = '{"stall",       2,  0, 20, 1'b0, 8'h10, 2, 1'b0};
        tbl[3] = '{"abort_xfer2", 4,  2,  0, 1'b0, 8'h40, 2, 1'b1};
        tbl[4] = '{"zero_len",    0,  0,  0, 1'b0, 8'h00, 0, 1'b0};
        tbl[5] = '{"abort_setup", 3, -1,  0, 1'b1, 8'h70, 0, 1'b1};
        tbl[6] = '{"abort_vs_hs", 2, -2,  0, 1'b0, 8'h80, 0, 1'b1};
        tbl[7] = '{"abort_last",  5,  5,  0, 1'b1, 8'hC0, 5, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", int'(bus.cs_n), 1);
        check("rst_pulses", int'({bus.rx_valid, bus.txn_done, bus.txn_aborted, bus.eng_start}), 0);
        check("rst_tx_ready", int'(bus.tx_ready), 0);
        check("rst_data", int'({bus.rx_data, bus.eng_tx_byte}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].name, tbl[i].len, tbl[i].abort_at, tbl[i].stall,
                    tbl[i].stray, tbl[i].base, tbl[i].exp_bytes, tbl[i].exp_ab);

        // Single-byte timing chain: setup, engine latency, hold and idle gap.
        run_txn("timing", 1, 0, 0, 1'b0, 8'hA5, 1, 1'b0);
        check("t_setup_to_start", start_cyc - fall_cyc, SETUP + 1);
        check("t_hs_to_start", start_cyc - hs_cyc, 1);
        check("t_done_to_rx", rx_cyc - edone_cyc, 1);
        check("t_rx_data", int'(rx_q[rx_q.size() - 1]), 8'h3C);
        check("t_hold", rise_cyc - rx_cyc, HOLD);
        check("t_idle_gap", done_cyc - rise_cyc, IDLE);

        // Reset while stalled in FETCH of a 3-byte command.
        begin
            int d0;
            int n = 0;
            wait_ready("rst_mid");
            d0            = done_cnt;
            bus.cmd_valid = 1'b1;
            bus.cmd_len   = 8'd3;
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            while (!bus.tx_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("rst_mid_reached_fetch", int'(bus.tx_ready), 1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("rst_mid_cs_n", int'(bus.cs_n), 1);
            check("rst_mid_cmd_ready", int'(bus.cmd_ready), 1);
            check("rst_mid_pulses", int'({bus.rx_valid, bus.txn_done, bus.txn_aborted, bus.eng_start}), 0);
            repeat (4) @(posedge clk);
            #1;
            check("rst_mid_no_txn_done", done_cnt - d0, 0);
            run_txn("after_rst", 1, 0, 0, 1'b0, 8'h5E, 1, 1'b0);
        end

        for (int t = 0; t < 40; t++) begin
            int len, ab, stall, r;
            bit stray;
            len   = int'($urandom_range(0, 6));
            r     = int'($urandom_range(0, 9));
            ab    = (r < 5) ? 0 : (r < 8) ? int'($urandom_range(1, len + 1)) : (r == 8) ? -1 : -2;
            stall = int'($urandom_range(0, 8));
            stray = 1'($urandom_range(0, 1));
            run_txn("rand", len, ab, stall, stray, 8'($urandom),
                    model_bytes(len, ab), model_aborted(len, ab));
        end

        check("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
